// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA raster path.
//   - Default 640x480@60 timing constants.
//   - calc_total : derives H_TOTAL / V_TOTAL from active + porches + sync.
//   - cnt_width  : width of a counter that must hold 0..total-1.
//   - addr_width : clog2 of the (scaled) visible memory size.
//   - vga_sync_t : sync/blank bundle that travels through the delay line.
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } vga_sync_t;

    // Idle level of the display controls: both syncs inactive (high), blanked.
    localparam vga_sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

    function automatic int calc_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    function automatic int addr_width(input int h_active, input int v_active,
                                      input int scale_log2);
        int cells;
        cells = (h_active >> scale_log2) * (v_active >> scale_log2);
        return (cells > 1) ? $clog2(cells) : 1;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// ---------------------------------------------------------------------------
// vga_delay_line
// Parametrised-depth shift register with a reset value. Used to line the
// sync/blank controls up with the colour data coming out of the memories.
//   clk   in  1      clock
//   rst_n in  1      synchronous active-low reset (flushes to RESET_VAL)
//   d     in  WIDTH  data in
//   q     out WIDTH  data out, DEPTH cycles later (DEPTH=0: q follows d)
// ---------------------------------------------------------------------------
module vga_delay_line #(
    parameter int               DEPTH     = 2,
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            // Zero depth is a plain wire; clock and reset are not needed.
            logic unused_ctrl;
            assign unused_ctrl = clk ^ rst_n;
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            // Every stage is flushed to the idle value so that nothing
            // from before a reset leaks out afterwards.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= RESET_VAL;
                    end
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_engine.sv
// ---------------------------------------------------------------------------
// vga_scan_engine
// Parametrised raster engine: sync/blank generation, index-memory read
// address with power-of-two pixel scaling, and a tear-free double-buffer
// bank swap applied at the start of vertical blank.
//   iVGA_CLK     in  1       pixel clock
//   iRST_n       in  1       synchronous active-low reset
//   iSWAP_REQ    in  1       writer finished the back bank (one-cycle pulse)
//   oADDR        out ADDR_W  index-memory read address (undelayed)
//   oBANK        out 1       bank being displayed / read
//   oWR_BANK     out 1       bank the writer may modify (~oBANK)
//   oSWAP_ACK    out 1       one-cycle pulse when the swap is applied
//   oHS          out 1       horizontal sync, active low, PIPE_DLY late
//   oVS          out 1       vertical sync, active low, PIPE_DLY late
//   oBLANK_n     out 1       high in the visible area, PIPE_DLY late
//   oFRAME_START out 1       high while the counters sit at (0,0)
//   oFRAME       out 16      frame counter, wraps
// ---------------------------------------------------------------------------
module vga_scan_engine
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int SCALE_LOG2 = 0,
    parameter int ADDR_W     = addr_width(H_ACTIVE, V_ACTIVE, SCALE_LOG2),
    parameter int PIPE_DLY   = 2
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              iSWAP_REQ,
    output logic [ADDR_W-1:0] oADDR,
    output logic              oBANK,
    output logic              oWR_BANK,
    output logic              oSWAP_ACK,
    output logic              oHS,
    output logic              oVS,
    output logic              oBLANK_n,
    output logic              oFRAME_START,
    output logic [15:0]       oFRAME
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int H_W     = cnt_width(H_TOTAL);
    localparam int V_W     = cnt_width(V_TOTAL);
    localparam int SYNC_W  = $bits(vga_sync_t);

    localparam logic [H_W-1:0]    H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]    V_LAST     = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]    V_SWAP     = V_W'(V_ACTIVE - 1);
    localparam logic [31:0]       H_ACT_32   = 32'(H_ACTIVE);
    localparam logic [31:0]       V_ACT_32   = 32'(V_ACTIVE);
    localparam logic [31:0]       H_SYNC_BEG = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0]       H_SYNC_END = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0]       V_SYNC_BEG = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0]       V_SYNC_END = 32'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [31:0]       SCALE_MASK = 32'((1 << SCALE_LOG2) - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(H_ACTIVE >> SCALE_LOG2);

    logic [H_W-1:0]    hcnt, hcnt_nxt;
    logic [V_W-1:0]    vcnt, vcnt_nxt, vcnt_inc;
    logic [ADDR_W-1:0] row_base, row_base_nxt;
    logic [ADDR_W-1:0] col_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic              h_end, v_end, frame_wrap;
    logic              visible_nxt;
    logic              pending, pending_nxt;
    logic              bank, bank_nxt;
    logic              swap_point_nxt, swap_nxt;
    logic              ack_q;
    logic              frame_start_q;
    logic [15:0]       frame_q, frame_nxt;
    vga_sync_t         sync_nxt, sync_q, sync_dly;
    logic [SYNC_W-1:0] sync_dly_bits;

    // Next-state of the raster. Everything registered below is computed from
    // the *next* counter values, so the registered address, sync and flags
    // describe the same pixel as the counters do. The address is built
    // incrementally: a row base that steps by one scaled line whenever a new
    // memory row begins, plus the scaled column taken straight off hcnt.
    always_comb begin
        h_end        = (hcnt == H_LAST);
        v_end        = (vcnt == V_LAST);
        frame_wrap   = h_end && v_end;
        vcnt_inc     = vcnt + 1'b1;
        hcnt_nxt     = h_end ? '0 : hcnt + 1'b1;
        vcnt_nxt     = vcnt;
        row_base_nxt = row_base;
        if (h_end) begin
            if (v_end) begin
                vcnt_nxt     = '0;
                row_base_nxt = '0;
            end else begin
                vcnt_nxt = vcnt_inc;
                if (((32'(vcnt_inc) & SCALE_MASK) == 32'd0) &&
                    (32'(vcnt_inc) < V_ACT_32)) begin
                    row_base_nxt = row_base + ROW_STEP;
                end
            end
        end

        col_nxt     = ADDR_W'(hcnt_nxt >> SCALE_LOG2);
        visible_nxt = (32'(hcnt_nxt) < H_ACT_32) && (32'(vcnt_nxt) < V_ACT_32);
        addr_nxt    = visible_nxt ? (row_base_nxt + col_nxt) : addr_q;

        sync_nxt.hs      = !((32'(hcnt_nxt) >= H_SYNC_BEG) && (32'(hcnt_nxt) < H_SYNC_END));
        sync_nxt.vs      = !((32'(vcnt_nxt) >= V_SYNC_BEG) && (32'(vcnt_nxt) < V_SYNC_END));
        sync_nxt.blank_n = visible_nxt;

        frame_nxt = frame_wrap ? frame_q + 16'd1 : frame_q;
    end

    // Bank swap handshake. The swap happens on the edge that brings the
    // counters onto the last pixel of the last visible line, so the bank bit
    // and the ack are both visible while the counters show that pixel. A
    // request sampled on that same edge joins the swap; any later request is
    // held as pending until the next frame. Multiple requests collapse into
    // one pending flag.
    always_comb begin
        swap_point_nxt = (hcnt_nxt == H_LAST) && (vcnt_nxt == V_SWAP);
        swap_nxt       = swap_point_nxt && (pending || iSWAP_REQ);
        bank_nxt       = swap_nxt ? ~bank : bank;
        pending_nxt    = swap_nxt ? 1'b0 : (pending || iSWAP_REQ);
    end

    // State register. Reset drops everything, including a pending swap,
    // back to the idle raster at (0,0) on bank 0.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            hcnt          <= '0;
            vcnt          <= '0;
            row_base      <= '0;
            addr_q        <= '0;
            bank          <= 1'b0;
            pending       <= 1'b0;
            ack_q         <= 1'b0;
            frame_q       <= '0;
            frame_start_q <= 1'b0;
            sync_q        <= SYNC_IDLE;
        end else begin
            hcnt          <= hcnt_nxt;
            vcnt          <= vcnt_nxt;
            row_base      <= row_base_nxt;
            addr_q        <= addr_nxt;
            bank          <= bank_nxt;
            pending       <= pending_nxt;
            ack_q         <= swap_nxt;
            frame_q       <= frame_nxt;
            frame_start_q <= frame_wrap;
            sync_q        <= sync_nxt;
        end
    end

    // Sync and blank are delayed so they match the colour produced from the
    // address issued PIPE_DLY cycles earlier.
    vga_delay_line #(
        .DEPTH     (PIPE_DLY),
        .WIDTH     (SYNC_W),
        .RESET_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .clk   (iVGA_CLK),
        .rst_n (iRST_n),
        .d     (sync_q),
        .q     (sync_dly_bits)
    );

    assign sync_dly     = vga_sync_t'(sync_dly_bits);
    assign oHS          = sync_dly.hs;
    assign oVS          = sync_dly.vs;
    assign oBLANK_n     = sync_dly.blank_n;
    assign oADDR        = addr_q;
    assign oBANK        = bank;
    assign oWR_BANK     = ~bank;
    assign oSWAP_ACK    = ack_q;
    assign oFRAME_START = frame_start_q;
    assign oFRAME       = frame_q;

endmodule

// File: tb/tb_vga_scan_engine.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_engine
// Directed bench for vga_scan_engine using the small 14x7 raster
// (H 8/2/2/2, V 4/1/1/1). Two instances run side by side: SCALE_LOG2=0 and
// SCALE_LOG2=1. A small position model tracks (hcnt,vcnt) in lockstep.
// ---------------------------------------------------------------------------
module tb_vga_scan_engine;

    localparam int HT = 14;
    localparam int VT = 7;
    localparam int HA = 8;
    localparam int VA = 4;

    logic clk = 1'b0;
    logic rstN;
    logic swapReq;

    logic [7:0]  addr0;
    logic        bank0, wrBank0, ack0, hs0, vs0, blank0, fs0;
    logic [15:0] frame0;

    logic [7:0]  addr1;
    logic        unusedBank1, unusedWrBank1, unusedAck1, unusedHs1;
    logic        unusedVs1, unusedBlank1, unusedFs1;
    logic [15:0] unusedFrame1;

    int checks;
    int errors;
    int t;
    int mh, mv;
    int frameM;
    bit bankM, pendM, ackM;
    int lastA0, lastA1;
    bit hsH[3], vsH[3], blH[3];
    bit havePrev;
    int fsPrev, blCnt, hsCnt, vsCnt, ackCnt, ackBase;

    always #5 clk = ~clk;

    vga_scan_engine #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SCALE_LOG2(0), .ADDR_W(8), .PIPE_DLY(2)
    ) dut0 (
        .iVGA_CLK(clk), .iRST_n(rstN), .iSWAP_REQ(swapReq),
        .oADDR(addr0), .oBANK(bank0), .oWR_BANK(wrBank0), .oSWAP_ACK(ack0),
        .oHS(hs0), .oVS(vs0), .oBLANK_n(blank0),
        .oFRAME_START(fs0), .oFRAME(frame0)
    );

    vga_scan_engine #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SCALE_LOG2(1), .ADDR_W(8), .PIPE_DLY(2)
    ) dut1 (
        .iVGA_CLK(clk), .iRST_n(rstN), .iSWAP_REQ(1'b0),
        .oADDR(addr1), .oBANK(unusedBank1), .oWR_BANK(unusedWrBank1),
        .oSWAP_ACK(unusedAck1), .oHS(unusedHs1), .oVS(unusedVs1),
        .oBLANK_n(unusedBlank1), .oFRAME_START(unusedFs1), .oFRAME(unusedFrame1)
    );

    // Single comparison point: counts every check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (h=%0d v=%0d t=%0d)",
                     tag, actual, expected, mh, mv, t);
        end
    endtask

    // Puts the model back at pixel (0,0) of an idle raster, as after reset.
    task automatic resetModel();
        t = 0; mh = 0; mv = 0; frameM = 0;
        bankM = 1'b0; pendM = 1'b0; ackM = 1'b0;
        lastA0 = 0; lastA1 = 0;
        for (int i = 0; i < 3; i++) begin
            hsH[i] = 1'b1; vsH[i] = 1'b1; blH[i] = 1'b0;
        end
        havePrev = 1'b0; blCnt = 0; hsCnt = 0; vsCnt = 0;
    endtask

    // One clock: advance the model, then compare every output against it.
    task automatic stepCycle();
        logic reqS;
        bit   vis;
        reqS = swapReq;
        @(posedge clk);
        #1;
        t++;
        if (mh == HT - 1) begin
            mh = 0;
            if (mv == VT - 1) begin
                mv = 0;
                frameM++;
            end else begin
                mv++;
            end
        end else begin
            mh++;
        end

        if (mh == 13 && mv == 3 && (pendM || reqS)) begin
            bankM = ~bankM; ackM = 1'b1; pendM = 1'b0;
        end else begin
            ackM = 1'b0; pendM = pendM | reqS;
        end

        vis = (mh < HA) && (mv < VA);
        if (vis) begin
            lastA0 = mv * HA + mh;
            lastA1 = (mv / 2) * (HA / 2) + (mh / 2);
        end
        hsH[2] = hsH[1]; hsH[1] = hsH[0]; hsH[0] = !(mh >= 10 && mh < 12);
        vsH[2] = vsH[1]; vsH[1] = vsH[0]; vsH[0] = (mv != 5);
        blH[2] = blH[1]; blH[1] = blH[0]; blH[0] = vis;

        checkOutput("addr_s0", addr0, lastA0);
        checkOutput("addr_s1", addr1, lastA1);
        checkOutput("frame_start", fs0, (mh == 0 && mv == 0));
        checkOutput("frame_cnt", frame0, frameM);
        checkOutput("bank", bank0, bankM);
        checkOutput("wr_bank", wrBank0, !bankM);
        checkOutput("swap_ack", ack0, ackM);
        if (t >= 3) begin
            checkOutput("hs_dly", hs0, hsH[2]);
            checkOutput("vs_dly", vs0, vsH[2]);
            checkOutput("blank_dly", blank0, blH[2]);
        end

        if (ack0 === 1'b1) ackCnt++;
        if (fs0 === 1'b1) begin
            if (havePrev) begin
                checkOutput("fs_period", t - fsPrev, 98);
                checkOutput("blank_per_frame", blCnt, 32);
                checkOutput("hs_low_per_frame", hsCnt, 14);
                checkOutput("vs_low_per_frame", vsCnt, 14);
            end
            havePrev = 1'b1; fsPrev = t;
            blCnt = 0; hsCnt = 0; vsCnt = 0;
        end
        if (blank0 === 1'b1) blCnt++;
        if (hs0 === 1'b0) hsCnt++;
        if (vs0 === 1'b0) vsCnt++;
    endtask

    // Runs until the model sits at (th,tv), at least one cycle, bounded.
    task automatic runTo(input int th, input int tv);
        int n;
        n = 0;
        do begin
            stepCycle();
            n++;
        end while (!(mh == th && mv == tv) && n < 200);
        if (!(mh == th && mv == tv)) checkOutput("runTo_bound", 0, 1);
    endtask

    // Drives a one-cycle swap request, sampled on the next edge.
    task automatic applyStimulus();
        swapReq = 1'b1;
        stepCycle();
        swapReq = 1'b0;
    endtask

    // Idle values expected whenever reset has just been applied.
    task automatic checkResetState(input string pfx);
        checkOutput({pfx, "_addr0"}, addr0, 0);
        checkOutput({pfx, "_addr1"}, addr1, 0);
        checkOutput({pfx, "_hs"}, hs0, 1);
        checkOutput({pfx, "_vs"}, vs0, 1);
        checkOutput({pfx, "_blank"}, blank0, 0);
        checkOutput({pfx, "_bank"}, bank0, 0);
        checkOutput({pfx, "_wr_bank"}, wrBank0, 1);
        checkOutput({pfx, "_ack"}, ack0, 0);
        checkOutput({pfx, "_fs"}, fs0, 0);
        checkOutput({pfx, "_frame"}, frame0, 0);
    endtask

    // Watchdog so the bench always ends on its own.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence.
    initial begin
        checks = 0; errors = 0; ackCnt = 0;
        rstN = 1'b0; swapReq = 1'b0;
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");

        rstN = 1'b1;
        resetModel();

        // First frame start lands exactly one frame (98 cycles) later.
        repeat (98) stepCycle();
        checkOutput("first_fs", fs0, 1);
        checkOutput("first_frame", frame0, 1);

        // Address sweep spots in frame 1, both scale settings.
        runTo(7, 0); checkOutput("sweep_7_0", addr0, 7);  checkOutput("s1_7_0", addr1, 3);
        runTo(0, 1); checkOutput("sweep_0_1", addr0, 8);  checkOutput("s1_0_1", addr1, 0);
        runTo(1, 2); checkOutput("sweep_1_2", addr0, 17); checkOutput("s1_1_2", addr1, 4);
        runTo(7, 3); checkOutput("sweep_7_3", addr0, 31); checkOutput("s1_7_3", addr1, 7);
        runTo(11, 3); checkOutput("hold_11_3", addr0, 31);
        runTo(0, 5);  checkOutput("hold_0_5", addr0, 31);
        runTo(0, 0);  checkOutput("wrap_addr", addr0, 0); checkOutput("frame2", frame0, 2);

        // Case 1: request mid-line 1, swap exactly at (13,3).
        runTo(4, 1);
        ackBase = ackCnt;
        applyStimulus();
        runTo(12, 3); checkOutput("c1_bank_before", bank0, 0);
        stepCycle();
        checkOutput("c1_ack_at_swap", ack0, 1);
        checkOutput("c1_bank_at_swap", bank0, 1);
        stepCycle();
        checkOutput("c1_ack_after", ack0, 0);
        checkOutput("c1_wr_bank_after", wrBank0, 0);
        runTo(0, 0);
        checkOutput("c1_single_ack", ackCnt - ackBase, 1);

        // Case 2a: three requests in one frame give one swap.
        ackBase = ackCnt;
        runTo(2, 0); applyStimulus();
        runTo(5, 1); applyStimulus();
        runTo(3, 2); applyStimulus();
        runTo(0, 0);
        checkOutput("c2a_one_swap", ackCnt - ackBase, 1);
        checkOutput("c2a_bank", bank0, 0);

        // Case 2b: request sampled on the edge entering the swap point.
        runTo(12, 3);
        applyStimulus();
        checkOutput("c2b_ack", ack0, 1);
        checkOutput("c2b_bank", bank0, 1);

        // Case 2c: request at vcnt=4 waits for the next frame's swap point.
        runTo(3, 4);
        ackBase = ackCnt;
        applyStimulus();
        runTo(13, 3);
        checkOutput("c2c_ack", ack0, 1);
        checkOutput("c2c_bank", bank0, 0);
        checkOutput("c2c_one_swap", ackCnt - ackBase, 1);

        // Get onto bank 1, then leave a swap pending before reset.
        runTo(0, 0); applyStimulus();
        runTo(0, 0); checkOutput("pre_rst_bank", bank0, 1);
        runTo(1, 2); applyStimulus();
        runTo(5, 2);
        checkOutput("pre_rst_addr", addr0, 21);
        checkOutput("pre_rst_blank", blank0, 1);

        // Reset mid-frame: one edge returns everything to idle.
        rstN = 1'b0;
        @(posedge clk);
        #1;
        checkResetState("midrst");
        rstN = 1'b1;
        resetModel();

        // The discarded pending swap must never show up.
        ackBase = ackCnt;
        repeat (2 * 98) stepCycle();
        checkOutput("midrst_no_ack", ackCnt - ackBase, 0);
        checkOutput("midrst_bank", bank0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_scan_engine.md
# vga_scan_engine

- Parametrised raster engine for the VGA path; the next generation of the fixed 640x480 sync generator and pixel address counter.
- Produces HS/VS/blank from parameterised timings and the index-memory read address, with power-of-two pixel scaling.
- Double-buffers the index memory via a bank bit: the writer side requests a bank swap, and the engine applies it only at the start of vertical blank, so no frame ever tears.
- Sits between the index memory and the colour table, with display outputs delayed to match their read latency.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, HS pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, VS pulse width
- V_BP, 33, vertical back porch
- SCALE_LOG2, 0, each memory pixel covers 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels
- ADDR_W, 19, read address width
- PIPE_DLY, 2, cycles from oADDR to valid colour (index RAM + colour ROM)

Ports:
- iVGA_CLK  in  1  pixel clock; the single clock of the block
- iRST_n  in  1  synchronous active-low reset
- iSWAP_REQ  in  1  one-cycle pulse: writer has finished the back bank
- oADDR  out  ADDR_W  index-memory read address (undelayed)
- oBANK  out  1  bank currently displayed; read bank select
- oWR_BANK  out  1  ~oBANK; bank the writer may modify
- oSWAP_ACK  out  1  one-cycle pulse when the swap is applied
- oHS  out  1  horizontal sync, active low, delayed PIPE_DLY
- oVS  out  1  vertical sync, active low, delayed PIPE_DLY
- oBLANK_n  out  1  high in the visible area, delayed PIPE_DLY
- oFRAME_START  out  1  pulse at hcnt=0, vcnt=0 (undelayed)
- oFRAME  out  16  frame counter, wraps

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- hcnt counts 0..H_TOTAL-1. vcnt increments when hcnt wraps, and itself wraps at V_TOTAL-1.
- Visible area: hcnt<H_ACTIVE and vcnt<V_ACTIVE.
- HS is low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); VS is low for the same range on vcnt.
- oADDR = (vcnt>>SCALE_LOG2)*(H_ACTIVE>>SCALE_LOG2) + (hcnt>>SCALE_LOG2).
  - Computed incrementally: a row-base register adds H_ACTIVE>>SCALE_LOG2 when a line ends and (vcnt+1) is a multiple of 2^SCALE_LOG2.
  - Column advances every 2^SCALE_LOG2 visible pixels.
  - No multiplier.
- Outside the visible area, oADDR holds its last value.
- Row base returns to 0 at frame wrap.
- Swap handshake:
  - iSWAP_REQ sets a pending flag.
  - At the swap point (hcnt=H_TOTAL-1, vcnt=V_ACTIVE-1), if pending: oBANK toggles, oSWAP_ACK pulses for one cycle, and pending clears.
  - Extra requests while pending are absorbed (one swap).
  - A request on the swap-point cycle itself is taken in that same swap.
  - A request arriving after the swap point waits for the next frame.
- oFRAME increments at every frame wrap.
- Reset values:
  - Counters, row base, oADDR, oBANK, pending, oFRAME: 0.
  - oHS=1, oVS=1, oBLANK_n=0, oSWAP_ACK=0, oFRAME_START=0.
  - The delay line is flushed to the same idle values.
- Reset asserted mid-frame: all state returns to the values above on the next edge. A pending swap is discarded.

## Timing
- Counters, oADDR and the bank bit update on the rising edge of iVGA_CLK.
- oHS, oVS and oBLANK_n are produced by a PIPE_DLY-stage shift register, so they line up with the colour data for the address issued PIPE_DLY cycles earlier.
- PIPE_DLY=0 is legal: outputs come straight from the comparators, registered once.
- oSWAP_ACK and oBANK change in the same cycle.
- The first visible address of the new bank is issued at the start of the next frame.

## Structure
- Shared package vga_pkg:
  - Default 640x480 timing constants.
  - H_TOTAL/V_TOTAL derivation functions.
  - Address-width helper (clog2 of the visible memory size).
- Natural sub-module: vga_delay_line (parametrised-depth shift register with reset value), used for the sync/blank alignment.

## Test plan
All scenarios use small timings: H 8/2/2/2 (H_TOTAL=14), V 4/1/1/1 (V_TOTAL=7), SCALE_LOG2=0, PIPE_DLY=2.
- Reset release, then run two frames:
  - oFRAME_START every 98 cycles.
  - oHS low at hcnt 10-11 (seen at the outputs 2 cycles later).
  - oVS low on line 5.
  - oBLANK_n high for 32 cycles per frame.
- Address sweep: oADDR runs 0..31 across the visible pixels in raster order and holds 31 during blanking.
- SCALE_LOG2=1 with the same timings: oADDR sequence on line 0 is 0,0,1,1,2,2,3,3; line 1 repeats it; lines 2-3 use 4..7.
- Swap request, case 1: iSWAP_REQ mid-line 1 gives oBANK 0->1 and a single oSWAP_ACK exactly at hcnt=13, vcnt=3; oWR_BANK=0 afterwards.
- Swap request, case 2:
  - Three requests within one frame produce one swap.
  - A request exactly at the swap point swaps in that same cycle.
  - A request at vcnt=4 swaps one frame later.
- Reset asserted at hcnt=5, vcnt=2 with a swap pending: next cycle counters=0, oHS=1, oBLANK_n=0, oBANK=0, and no oSWAP_ACK ever follows.
